// File: rtl/fpga_boot_ctrl.sv
// Boot sequencer: waits for a stable PLL lock, releases reset domains in order, then enables core fetch.
// Optional lock-loss counter compiled in with `define BOOT_CTRL_LOCK_LOSS_CNT_EN.
module fpga_boot_ctrl #(
  parameter int unsigned NUM_DOMAINS        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DOMAIN_GAP_CYCLES  = 16,
  parameter int unsigned FETCH_DELAY_CYCLES = 64,
  parameter int unsigned HB_DIV_LOG2        = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   fetch_enable,
  output logic [2:0]             boot_state,
  output logic [3:0]             led,
  output logic [7:0]             lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > DOMAIN_GAP_CYCLES) ?
                                    LOCK_STABLE_CYCLES : DOMAIN_GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_AB > FETCH_DELAY_CYCLES) ? MAX_AB : FETCH_DELAY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS) + 1;
  localparam int unsigned HB_W    = HB_DIV_LOG2 + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOMAIN_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST  = CNT_W'(FETCH_DELAY_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_STABLE    = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_FETCH_DLY = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  logic                   r_lock_meta;
  logic                   r_locked_s;
  logic [2:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_dom;
  logic                   r_fetch;
  logic [3:0]             r_led;
  logic [HB_W-1:0]        r_hb;

  logic [2:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [NUM_DOMAINS-1:0] w_dom_nxt;
  logic                   w_fetch_nxt;
  logic [HB_W-1:0]        w_hb_nxt;
  logic [3:0]             w_led_nxt;
  logic                   w_active;

  assign w_active = (r_state == S_RELEASE) || (r_state == S_FETCH_DLY) || (r_state == S_RUN);
  assign w_hb_nxt = r_hb + HB_W'(1);

  // Next-state logic; lock loss overrides soft reset, which overrides normal sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_dom_nxt   = r_dom;
    w_fetch_nxt = r_fetch;

    case (r_state)
      S_WAIT_LOCK: begin
        w_dom_nxt   = '0;
        w_fetch_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (r_locked_s) begin
          w_state_nxt = S_STABLE;
        end
      end
      S_STABLE: begin
        if (r_cnt == STABLE_LAST) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (r_cnt == GAP_LAST) begin
          for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
            if (IDX_W'(i) == r_idx) begin
              w_dom_nxt[i] = 1'b1;
            end
          end
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_FETCH_DLY;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FETCH_DLY: begin
        if (r_cnt == FETCH_LAST) begin
          w_state_nxt = S_RUN;
          w_fetch_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_fetch_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_dom_nxt   = '0;
        w_fetch_nxt = 1'b0;
      end
    endcase

    if (soft_rst_req && w_active) begin
      w_state_nxt = S_STABLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_dom_nxt   = '0;
      w_fetch_nxt = 1'b0;
    end

    if (!r_locked_s && (r_state != S_WAIT_LOCK)) begin
      w_state_nxt = S_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_dom_nxt   = '0;
      w_fetch_nxt = 1'b0;
    end
  end

  assign w_led_nxt = {(w_state_nxt == S_WAIT_LOCK) & w_hb_nxt[HB_DIV_LOG2-2],
                      w_fetch_nxt,
                      r_lock_meta,
                      (w_state_nxt == S_RUN) & w_hb_nxt[HB_DIV_LOG2]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_dom       <= '0;
      r_fetch     <= 1'b0;
      r_led       <= '0;
      r_hb        <= '0;
    end else begin
      r_lock_meta <= pll_locked;
      r_locked_s  <= r_lock_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_dom       <= w_dom_nxt;
      r_fetch     <= w_fetch_nxt;
      r_led       <= w_led_nxt;
      r_hb        <= w_hb_nxt;
    end
  end

  assign domain_rst_n = r_dom;
  assign fetch_enable = r_fetch;
  assign boot_state   = r_state;
  assign led          = r_led;

`ifdef BOOT_CTRL_LOCK_LOSS_CNT_EN
  logic       w_loss_evt;
  logic [7:0] r_loss;

  assign w_loss_evt = !r_locked_s && w_active;

  // Saturating count of lock losses once release has begun
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_loss <= 8'h00;
    end else if (w_loss_evt && (r_loss != 8'hFF)) begin
      r_loss <= r_loss + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss;
`else
  assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fpga_boot_ctrl.sv
// Self-checking bench for fpga_boot_ctrl: directed boot/loss/soft-reset scenarios, then random lock and request traffic.
module tb_fpga_boot_ctrl;

  localparam int ND    = 3;
  localparam int LSC   = 16;
  localparam int DGC   = 4;
  localparam int FDC   = 8;
  localparam int HB    = 4;
  localparam int T_REL = LSC;
  localparam int T_FET = LSC + ND * DGC;
  localparam int T_RUN = T_FET + FDC;
`ifdef BOOT_CTRL_LOCK_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic          clk_sys;
  logic          reset;
  logic          pll_locked;
  logic          soft_rst_req;
  logic [ND-1:0] domain_rst_n;
  logic          fetch_enable;
  logic [2:0]    boot_state;
  logic [3:0]    led;
  logic [7:0]    lock_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // Model: sequence progress is a single elapsed-cycle count since entering STABLE
  bit m_meta = 0;
  bit m_ls   = 0;
  bit m_seq  = 0;
  int m_t    = 0;
  int m_loss = 0;
  int m_hb   = 0;

  fpga_boot_ctrl #(
    .NUM_DOMAINS(ND), .LOCK_STABLE_CYCLES(LSC), .DOMAIN_GAP_CYCLES(DGC),
    .FETCH_DELAY_CYCLES(FDC), .HB_DIV_LOG2(HB)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .domain_rst_n(domain_rst_n), .fetch_enable(fetch_enable), .boot_state(boot_state),
    .led(led), .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic int m_state();
    if (!m_seq) return 0;
    if (m_t < T_REL) return 1;
    if (m_t < T_FET) return 2;
    if (m_t < T_RUN) return 3;
    return 4;
  endfunction

  function automatic int m_dom();
    int k;
    k = (m_state() < 2) ? 0 : (m_t - T_REL) / DGC;
    if (k > ND) k = ND;
    return (1 << k) - 1;
  endfunction

  function automatic int m_led();
    int st;
    int l;
    st = m_state();
    l  = 0;
    if (st == 4 && ((m_hb >> HB) & 1) == 1) l = l | 1;
    if (m_ls) l = l | 2;
    if (st == 4) l = l | 4;
    if (st == 0 && ((m_hb >> (HB - 2)) & 1) == 1) l = l | 8;
    return l;
  endfunction

  task automatic model_edge(input bit l, input bit s, input bit r);
    int st;
    bit old_ls;
    if (r) begin
      m_meta = 0; m_ls = 0; m_seq = 0; m_t = 0; m_loss = 0; m_hb = 0;
    end else begin
      st     = m_state();
      old_ls = m_ls;
      m_ls   = m_meta;
      m_meta = l;
      m_hb   = (m_hb + 1) % (1 << (HB + 1));
      if (!m_seq) begin
        if (old_ls) begin
          m_seq = 1;
          m_t   = 0;
        end
      end else if (!old_ls) begin
        m_seq = 0;
        m_t   = 0;
        if (st >= 2 && m_loss < 255) m_loss = m_loss + 1;
      end else if (s && st >= 2) begin
        m_t = 0;
      end else if (m_t < T_RUN) begin
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit l, input bit s, input bit r);
    @(negedge clk_sys);
    pll_locked   = l;
    soft_rst_req = s;
    reset        = r;
    @(posedge clk_sys);
    model_edge(l, s, r);
  endtask

  task automatic run(input int n, input bit l);
    for (int i = 0; i < n; i++) step(l, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("boot_state", int'(boot_state), m_state());
      chk("domain_rst_n", int'(domain_rst_n), m_dom());
      chk("fetch_enable", int'(fetch_enable), (m_state() == 4) ? 1 : 0);
      chk("led", int'(led), m_led());
      chk("lock_loss_cnt", int'(lock_loss_cnt), LOSS_EN ? m_loss : 0);
    end
  end

  initial begin
    int low_left;
    bit l;
    bit s;
    bit r;
    reset = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    chk_en = 1;
    #1;
    chk("rst_state", int'(boot_state), 0);
    chk("rst_dom", int'(domain_rst_n), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_loss", int'(lock_loss_cnt), 0);

    // Boot: two synchroniser cycles, then STABLE
    run(2, 1'b1);  #1 chk("pre_stable", int'(boot_state), 0);
    run(1, 1'b1);  #1 chk("stable", int'(boot_state), 1);
    chk("model_stable", m_state(), 1);
    run(LSC, 1'b1); #1 chk("release", int'(boot_state), 2);
    chk("dom_000", int'(domain_rst_n), 0);
    run(DGC, 1'b1); #1 chk("dom_001", int'(domain_rst_n), 1);
    run(DGC, 1'b1); #1 chk("dom_011", int'(domain_rst_n), 3);
    chk("model_dom_011", m_dom(), 3);
    run(DGC, 1'b1); #1 chk("dom_111", int'(domain_rst_n), 7);
    chk("fetch_dly", int'(boot_state), 3);
    run(FDC - 1, 1'b1); #1 chk("fetch_early", int'(fetch_enable), 0);
    run(1, 1'b1);  #1 chk("fetch_on", int'(fetch_enable), 1);
    chk("run", int'(boot_state), 4);

    // Lock loss in RUN
    run(2, 1'b0);  #1 chk("loss_pending", int'(boot_state), 4);
    run(1, 1'b0);  #1 chk("loss_state", int'(boot_state), 0);
    chk("loss_dom", int'(domain_rst_n), 0);
    chk("loss_cnt1", int'(lock_loss_cnt), LOSS_EN);
    chk("model_loss1", m_loss, 1);
    run(3 + T_RUN, 1'b1); #1 chk("relock_run", int'(boot_state), 4);

    // Soft reset in RUN
    step(1'b1, 1'b1, 1'b0); #1 chk("soft_state", int'(boot_state), 1);
    chk("soft_dom", int'(domain_rst_n), 0);
    chk("soft_fetch", int'(fetch_enable), 0);
    run(T_RUN - 1, 1'b1); #1 chk("soft_fetch_early", int'(fetch_enable), 0);
    run(1, 1'b1);  #1 chk("soft_fetch_back", int'(fetch_enable), 1);

    // Glitch during STABLE around count 10
    step(1'b1, 1'b1, 1'b0);
    run(10, 1'b1);
    run(1, 1'b0);
    run(2, 1'b1);  #1 chk("glitch_wait", int'(boot_state), 0);
    chk("glitch_loss", int'(lock_loss_cnt), LOSS_EN);
    run(1, 1'b1);  #1 chk("glitch_restable", int'(boot_state), 1);
    run(LSC - 1, 1'b1); #1 chk("glitch_restart", int'(boot_state), 1);
    run(1, 1'b1);  #1 chk("glitch_release", int'(boot_state), 2);

    // Soft request on the cycle locked_s falls: loss wins
    run(T_RUN - LSC, 1'b1); #1 chk("pre_coincide", int'(boot_state), 4);
    run(2, 1'b0);
    step(1'b0, 1'b1, 1'b0); #1 chk("coincide_state", int'(boot_state), 0);
    chk("coincide_loss", int'(lock_loss_cnt), 2 * LOSS_EN);

    // Reset while two domains released
    run(3 + LSC + 2 * DGC, 1'b1); #1 chk("pre_rst_dom", int'(domain_rst_n), 3);
    step(1'b1, 1'b0, 1'b1); #1 chk("midrst_dom", int'(domain_rst_n), 0);
    chk("midrst_state", int'(boot_state), 0);
    chk("midrst_led", int'(led), 0);
    chk("midrst_loss", int'(lock_loss_cnt), 0);

    // Random lock glitches, soft requests and occasional resets
    low_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (low_left > 0) begin
        low_left = low_left - 1;
        l = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        low_left = int'($urandom_range(0, 3));
        l = 1'b0;
      end else begin
        l = 1'b1;
      end
      s = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 999) == 0);
      step(l, s, r);
    end

    @(negedge clk_sys);
    #1;
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
